// File: rtl/kf6845_pkg.sv
// Shared constants, power-up mode table and scheduler state encoding
// for the KF6845 register-write scheduler.
`default_nettype none

package kf6845_pkg;

    localparam logic [3:0] R0  = 4'd0;
    localparam logic [3:0] R1  = 4'd1;
    localparam logic [3:0] R2  = 4'd2;
    localparam logic [3:0] R3  = 4'd3;
    localparam logic [3:0] R4  = 4'd4;
    localparam logic [3:0] R5  = 4'd5;
    localparam logic [3:0] R6  = 4'd6;
    localparam logic [3:0] R7  = 4'd7;
    localparam logic [3:0] R8  = 4'd8;
    localparam logic [3:0] R9  = 4'd9;
    localparam logic [3:0] R10 = 4'd10;
    localparam logic [3:0] R11 = 4'd11;
    localparam logic [3:0] R12 = 4'd12;
    localparam logic [3:0] R13 = 4'd13;
    localparam logic [3:0] R14 = 4'd14;
    localparam logic [3:0] R15 = 4'd15;

    // Timing registers whose writes may be held back to a frame boundary.
    localparam logic [15:0] DEFER_MASK = 16'h03FF;

    // 80x25 power-up mode, element n is the value written to Rn.
    localparam logic [15:0][7:0] INIT_TABLE = {
        8'h00, 8'h00, 8'h00, 8'h00, 8'h07, 8'h06, 8'h07, 8'h02,
        8'h1C, 8'h19, 8'h06, 8'h1F, 8'h0A, 8'h5A, 8'h50, 8'h71
    };

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic [15:0] reg_strobe(input logic [3:0] idx);
        reg_strobe = 16'd1 << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/kf6845_write_fifo.sv
// Deferred-write queue: synchronous FIFO that accepts a push while full
// provided a pop happens in the same cycle.
`default_nettype none

module kf6845_write_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)
                count_q <= count_q + CW'(1);
            else if (pop_ok && !push_ok)
                count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

`default_nettype wire

// File: rtl/kf6845_register_scheduler.sv
// Register-write scheduler: plays the power-up table, then issues CPU
// register writes immediately or defers timing registers to V_total.
`default_nettype none

module kf6845_register_scheduler
    import kf6845_pkg::*;
#(
    parameter bit INIT_ENABLE = 1'b1,
    parameter int FIFO_DEPTH  = 4,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_write,
    input  logic        cpu_rs,
    input  logic [7:0]  cpu_data,
    input  logic        V_total,
    input  logic        defer_enable,
    input  logic        clear_overflow,
    output logic [7:0]  internal_data_bus,
    output logic [15:0] write_register,
    output logic [4:0]  address_register,
    output logic        init_done,
    output logic        fifo_empty,
    output logic        overflow
);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic [15:0] strobe_q, strobe_d;
    logic [4:0]  addr_q;
    logic        init_done_q, init_done_d;
    logic        overflow_q;

    logic        wr_data, deferred, push, imm, pop, drop, drain_done;
    logic        fifo_full;
    logic [11:0] fifo_head;
    logic [CW-1:0] fifo_count;

    assign wr_data  = cpu_write & cpu_rs & ~addr_q[4];
    assign deferred = (DEFER_MASK[addr_q[3:0]] & defer_enable) | (state_q == ST_INIT);
    assign push     = wr_data & deferred;
    assign imm      = wr_data & ~deferred;
    // An immediate write owns the port, so the drain waits a cycle behind it.
    assign pop      = (state_q == ST_DRAIN) & ~fifo_empty & ~imm;
    assign drop     = push & fifo_full & ~pop;
    assign drain_done = pop & (fifo_count == CW'(1)) & ~push;

    kf6845_write_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (12)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ({addr_q[3:0], cpu_data}),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        data_d      = data_q;
        strobe_d    = '0;
        unique case (state_q)
            ST_INIT: begin
                data_d   = INIT_TABLE[idx_q];
                strobe_d = reg_strobe(idx_q);
                idx_d    = idx_q + 4'd1;
                if (idx_q == R15) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (V_total && !fifo_empty) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (imm) begin
            data_d   = cpu_data;
            strobe_d = reg_strobe(addr_q[3:0]);
        end else if (pop) begin
            data_d   = fifo_head[7:0];
            strobe_d = reg_strobe(fifo_head[11:8]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= INIT_ENABLE ? ST_INIT : ST_IDLE;
            idx_q       <= '0;
            init_done_q <= INIT_ENABLE ? 1'b0 : 1'b1;
            data_q      <= '0;
            strobe_q    <= '0;
            addr_q      <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
            data_q      <= data_d;
            strobe_q    <= strobe_d;
            if (cpu_write && !cpu_rs) addr_q <= cpu_data[4:0];
            if (drop)
                overflow_q <= 1'b1;
            else if (clear_overflow)
                overflow_q <= 1'b0;
        end
    end

    assign internal_data_bus = data_q;
    assign write_register    = strobe_q;
    assign address_register  = addr_q;
    assign init_done         = init_done_q;
    assign overflow          = overflow_q;

endmodule

`default_nettype wire
